// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage: PC reset value, PC step and fetch FSM states.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'hbfc0_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/redirect_sel.sv
// Redirect priority mux: a cp0 exception/eret redirect wins over a branch/jump redirect.
module redirect_sel
    import cpu_pkg::*;
(
    input  logic            flush_exception,
    input  logic [XLEN-1:0] pc_exception,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            redir,
    output logic [XLEN-1:0] tgt
);

    assign redir = flush_exception | branch_taken;
    assign tgt   = flush_exception ? pc_exception : branch_target;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// F-stage PC owner and instruction-bus master (req/addr_ok/data_ok, one transaction outstanding).
// Optional macro FETCH_ADEL_CHECK_EN: misaligned PCs skip the bus and present a nop flagged pcErrorF.
module fetch_pc_ctrl
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            flush_exception,
    input  logic [XLEN-1:0] pc_exception,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            inst_req,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [XLEN-1:0] inst_rdata,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] instF,
    output logic            inst_validF,
    output logic            pcErrorF
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            misaligned;

    redirect_sel u_redirect_sel (
        .flush_exception (flush_exception),
        .pc_exception    (pc_exception),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .redir           (redir),
        .tgt             (tgt)
    );

`ifdef FETCH_ADEL_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign inst_addr  = pc_q;
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {pc_q[XLEN-1:2], 2'b00};
`endif

    assign inst_req    = (state_q == S_REQ) && !misaligned;
    assign pcF         = pc_q;
    assign instF       = inst_q;
    assign inst_validF = valid_q;
    assign pcErrorF    = err_q;

    // Next-state logic; an accepted address always leaves exactly one data_ok to absorb.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_REQ: begin
                if (redir) begin
                    pc_d = tgt;
                    if (inst_addr_ok && inst_req) state_d = S_DROP;
                end else if (misaligned) begin
                    inst_d  = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = inst_data_ok ? S_REQ : S_DROP;
                end else if (inst_data_ok) begin
                    inst_d  = inst_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end else if (!stallF) begin
                    pc_d    = pc_q + PC_STEP;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redir) pc_d = tgt;
                if (inst_data_ok) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl; misaligned-fetch expectations follow FETCH_ADEL_CHECK_EN.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        flush_exception;
    logic [31:0] pc_exception;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] instF;
    logic        inst_validF;
    logic        pcErrorF;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallF          (stallF),
        .flush_exception (flush_exception),
        .pc_exception    (pc_exception),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .pcF             (pcF),
        .instF           (instF),
        .inst_validF     (inst_validF),
        .pcErrorF        (pcErrorF)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallF          = 1'b0;
        flush_exception = 1'b0;
        pc_exception    = '0;
        branch_taken    = 1'b0;
        branch_target   = '0;
        inst_addr_ok    = 1'b0;
        inst_data_ok    = 1'b0;
        inst_rdata      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        n_checks++;
        if ({inst_req, inst_addr, pcF, instF, inst_validF, pcErrorF} !==
            {1'b1, 32'hbfc00000, 32'hbfc00000, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b addr=%h pc=%h inst=%h v=%b err=%b, want 1 bfc00000 bfc00000 0 0 0",
                     inst_req, inst_addr, pcF, instF, inst_validF, pcErrorF);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        n_checks++;
        if ({inst_req, inst_validF} !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_wait: req=%b v=%b, want 0 0", inst_req, inst_validF);
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h1111_1111;
        cyc();
        inst_data_ok = 1'b0;
        n_checks++;
        if ({inst_validF, pcF, instF} !== {1'b1, 32'hbfc00000, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL seq_present: v=%b pc=%h inst=%h, want 1 bfc00000 11111111", inst_validF, pcF, instF);
        end
        cyc();
        n_checks++;
        if ({inst_req, inst_addr, inst_validF} !== {1'b1, 32'hbfc00004, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_next: req=%b addr=%h v=%b, want 1 bfc00004 0", inst_req, inst_addr, inst_validF);
        end
    endtask

    task automatic test_branch_in_wait();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok  = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_1000;
        cyc();
        branch_taken = 1'b0;
        n_checks++;
        if ({inst_req, inst_validF, pcF} !== {1'b0, 1'b0, 32'h8000_1000}) begin
            n_fail++;
            $display("FAIL br_wait_drop: req=%b v=%b pc=%h, want 0 0 80001000", inst_req, inst_validF, pcF);
        end
        cyc();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hdead_beef;
        cyc();
        inst_data_ok = 1'b0;
        n_checks++;
        if ({inst_req, inst_addr, inst_validF, instF} !== {1'b1, 32'h8000_1000, 1'b0, 32'h1111_1111}) begin
            n_fail++;
            $display("FAIL br_wait_next: req=%b addr=%h v=%b inst=%h, want 1 80001000 0 11111111",
                     inst_req, inst_addr, inst_validF, instF);
        end
    endtask

    task automatic test_exc_priority();
        flush_exception = 1'b1;
        pc_exception    = 32'hbfc0_0380;
        branch_taken    = 1'b1;
        branch_target   = 32'h8000_2000;
        cyc();
        clear_inputs();
        n_checks++;
        if ({inst_req, inst_addr, pcF} !== {1'b1, 32'hbfc0_0380, 32'hbfc0_0380}) begin
            n_fail++;
            $display("FAIL exc_priority: req=%b addr=%h pc=%h, want 1 bfc00380 bfc00380", inst_req, inst_addr, pcF);
        end
    endtask

    task automatic test_redirect_in_req();
        branch_taken  = 1'b1;
        branch_target = 32'h8000_3000;
        inst_addr_ok  = 1'b1;
        cyc();
        clear_inputs();
        n_checks++;
        if ({inst_req, pcF, inst_validF} !== {1'b0, 32'h8000_3000, 1'b0}) begin
            n_fail++;
            $display("FAIL req_redir_drop: req=%b pc=%h v=%b, want 0 80003000 0", inst_req, pcF, inst_validF);
        end
        cyc();
        n_checks++;
        if (inst_req !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_wait: req=%b, want 0", inst_req);
        end
        flush_exception = 1'b1;
        pc_exception    = 32'h8000_4000;
        inst_data_ok    = 1'b1;
        inst_rdata      = 32'h5555_5555;
        cyc();
        clear_inputs();
        n_checks++;
        if ({inst_req, inst_addr, inst_validF} !== {1'b1, 32'h8000_4000, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_redir_data: req=%b addr=%h v=%b, want 1 80004000 0", inst_req, inst_addr, inst_validF);
        end
    endtask

    task automatic test_stall();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2402_0001;
        stallF       = 1'b1;
        cyc();
        inst_data_ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({inst_req, inst_validF, pcF, instF} !== {1'b0, 1'b1, 32'h8000_4000, 32'h2402_0001}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b v=%b pc=%h inst=%h, want 0 1 80004000 24020001",
                         i, inst_req, inst_validF, pcF, instF);
            end
            if (i == 5) stallF = 1'b0;
            cyc();
        end
        n_checks++;
        if ({inst_req, inst_addr, inst_validF} !== {1'b1, 32'h8000_4004, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_release: req=%b addr=%h v=%b, want 1 80004004 0", inst_req, inst_addr, inst_validF);
        end
    endtask

    task automatic test_wrap();
        branch_taken  = 1'b1;
        branch_target = 32'hffff_fffc;
        cyc();
        clear_inputs();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0000_000c;
        cyc();
        inst_data_ok = 1'b0;
        n_checks++;
        if ({inst_validF, pcF} !== {1'b1, 32'hffff_fffc}) begin
            n_fail++;
            $display("FAIL wrap_present: v=%b pc=%h, want 1 fffffffc", inst_validF, pcF);
        end
        cyc();
        n_checks++;
        if ({inst_req, inst_addr, pcF} !== {1'b1, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_next: req=%b addr=%h pc=%h, want 1 0 0", inst_req, inst_addr, pcF);
        end
    endtask

    task automatic test_back_to_back();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'haaaa_5555;
        cyc();
        inst_data_ok  = 1'b0;
        stallF        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_5000;
        cyc();
        clear_inputs();
        n_checks++;
        if ({inst_req, inst_addr, inst_validF} !== {1'b1, 32'h8000_5000, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_redir_over_stall: req=%b addr=%h v=%b, want 1 80005000 0",
                     inst_req, inst_addr, inst_validF);
        end
    endtask

    task automatic test_misaligned();
        flush_exception = 1'b1;
        pc_exception    = 32'h8000_0002;
        cyc();
        clear_inputs();
`ifdef FETCH_ADEL_CHECK_EN
        n_checks++;
        if ({inst_req, pcF} !== {1'b0, 32'h8000_0002}) begin
            n_fail++;
            $display("FAIL adel_no_req: req=%b pc=%h, want 0 80000002", inst_req, pcF);
        end
        cyc();
        n_checks++;
        if ({inst_req, inst_validF, pcErrorF, instF} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL adel_present: req=%b v=%b err=%b inst=%h, want 0 1 1 0",
                     inst_req, inst_validF, pcErrorF, instF);
        end
        stallF          = 1'b1;
        flush_exception = 1'b1;
        pc_exception    = 32'hbfc0_0380;
        cyc();
        clear_inputs();
        n_checks++;
        if ({inst_req, pcErrorF, inst_validF, pcF} !== {1'b1, 1'b0, 1'b0, 32'hbfc0_0380}) begin
            n_fail++;
            $display("FAIL adel_clear: req=%b err=%b v=%b pc=%h, want 1 0 0 bfc00380",
                     inst_req, pcErrorF, inst_validF, pcF);
        end
`else
        n_checks++;
        if ({inst_req, inst_addr, pcF, pcErrorF} !== {1'b1, 32'h8000_0000, 32'h8000_0002, 1'b0}) begin
            n_fail++;
            $display("FAIL misaligned_addr: req=%b addr=%h pc=%h err=%b, want 1 80000000 80000002 0",
                     inst_req, inst_addr, pcF, pcErrorF);
        end
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0000_0000;
        cyc();
        inst_data_ok = 1'b0;
        n_checks++;
        if ({inst_validF, pcErrorF, pcF} !== {1'b1, 1'b0, 32'h8000_0002}) begin
            n_fail++;
            $display("FAIL misaligned_present: v=%b err=%b pc=%h, want 1 0 80000002", inst_validF, pcErrorF, pcF);
        end
        cyc();
        n_checks++;
        if ({inst_req, inst_addr, pcF} !== {1'b1, 32'h8000_0004, 32'h8000_0006}) begin
            n_fail++;
            $display("FAIL misaligned_next: req=%b addr=%h pc=%h, want 1 80000004 80000006", inst_req, inst_addr, pcF);
        end
`endif
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1;
        cyc();
        inst_addr_ok = 1'b0;
        rst          = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({inst_req, inst_addr, pcF, inst_validF} !== {1'b1, 32'hbfc00000, 32'hbfc00000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b addr=%h pc=%h v=%b, want 1 bfc00000 bfc00000 0",
                     inst_req, inst_addr, pcF, inst_validF);
        end
        cyc();
        n_checks++;
        if ({inst_req, pcF} !== {1'b1, 32'hbfc00000}) begin
            n_fail++;
            $display("FAIL reset_mid_req: req=%b pc=%h, want 1 bfc00000", inst_req, pcF);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_in_wait();
        test_exc_priority();
        test_redirect_in_req();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
